hall_speed_meter: RTL and testbench

//   Consumes the hall decoder's registered one-cycle edge strobe and direction bit.

---
 rtl/hall_pkg.sv | 37 +++
 rtl/hall_window_acc.sv | 81 ++++++++
 rtl/hall_speed_meter.sv | 163 ++++++++++++++++
 tb/tb_hall_speed_meter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hall_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : hall_pkg
//  Description : Shared types and saturation helpers for the hall speed path.
//                Also used by the motor speed controller so that both ends of
//                the interface agree on state encoding and counter limits.
//  Contents    : hall_state_e     - speed-meter FSM states
//                GAP_MAX          - saturation value of a default-width gap counter
//                gap_max()        - all-ones value of an unsigned counter of width w
//                win_max/win_min  - two's complement limits of a signed width w
//  Revision    : 1.0  initial release
// ============================================================================
package hall_pkg;

  typedef enum logic [1:0] {
    ST_STALL = 2'd0,
    ST_FIRST = 2'd1,
    ST_RUN   = 2'd2
  } hall_state_e;

  localparam int DEF_PERIOD_W = 16;
  localparam logic [DEF_PERIOD_W-1:0] GAP_MAX = '1;

  function automatic longint gap_max(input int w);
    return (longint'(1) << w) - longint'(1);
  endfunction

  function automatic longint win_max(input int w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  function automatic longint win_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/hall_window_acc.sv
`default_nettype none
// ============================================================================
//  Module      : hall_window_acc
//  Description : Fixed-window signed edge counter. A free-running window timer
//                closes a window every WINDOW_CYCLES clocks; accepted edges
//                inside the window are summed (+1 up / -1 down, saturating) and
//                the total is published at the close.
//  Ports       : Clk          in   system clock
//                reset        in   synchronous, active-low reset
//                acc          in   edge accepted this cycle
//                dir          in   direction of the accepted edge, 1 = up
//                speed_count  out  signed edge total of the last full window
//                window_valid out  one-cycle strobe at each window close
//  Revision    : 1.0  initial release
// ============================================================================
module hall_window_acc
  import hall_pkg::*;
#(
  parameter int WINDOW_CYCLES = 50000,
  parameter int WIN_W         = 16
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             acc,
  input  logic             dir,
  output logic [WIN_W-1:0] speed_count,
  output logic             window_valid
);

  localparam int WC_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WC_W-1:0]         C_WIN_LAST = WC_W'(WINDOW_CYCLES - 1);
  localparam logic [WC_W-1:0]         C_WC_ONE   = WC_W'(1);
  localparam logic signed [WIN_W-1:0] C_WIN_MAX  = WIN_W'(win_max(WIN_W));
  localparam logic signed [WIN_W-1:0] C_WIN_MIN  = WIN_W'(win_min(WIN_W));
  localparam logic signed [WIN_W-1:0] C_ONE      = WIN_W'(1);

  logic [WC_W-1:0]         win_cnt_q, win_cnt_d;
  logic signed [WIN_W-1:0] edge_acc_q, edge_acc_d;
  logic signed [WIN_W-1:0] edge_sum;
  logic [WIN_W-1:0]        speed_count_q, speed_count_d;
  logic                    window_valid_q, window_valid_d;
  logic                    win_close;

  always_comb begin
    // edge_sum includes this cycle's edge so an edge on the closing cycle
    // lands in the window being closed.
    edge_sum = edge_acc_q;
    if (acc) begin
      if (dir) begin
        if (edge_acc_q != C_WIN_MAX) edge_sum = edge_acc_q + C_ONE;
      end else begin
        if (edge_acc_q != C_WIN_MIN) edge_sum = edge_acc_q - C_ONE;
      end
    end

    win_close      = (win_cnt_q == C_WIN_LAST);
    win_cnt_d      = win_close ? '0 : win_cnt_q + C_WC_ONE;
    edge_acc_d     = win_close ? '0 : edge_sum;
    speed_count_d  = win_close ? edge_sum : speed_count_q;
    window_valid_d = win_close;
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      win_cnt_q      <= '0;
      edge_acc_q     <= '0;
      speed_count_q  <= '0;
      window_valid_q <= 1'b0;
    end else begin
      win_cnt_q      <= win_cnt_d;
      edge_acc_q     <= edge_acc_d;
      speed_count_q  <= speed_count_d;
      window_valid_q <= window_valid_d;
    end
  end

  assign speed_count  = speed_count_q;
  assign window_valid = window_valid_q;

endmodule
`default_nettype wire

// File: rtl/hall_speed_meter.sv
`default_nettype none
// ============================================================================
//  Module      : hall_speed_meter
//  Description : Turns the hall decoder's edge strobe and direction into a
//                wrapping position count, a per-edge period measurement with
//                stall detection, and a fixed-window signed speed count.
//                Edges closer than MIN_GAP clocks to the previous accepted edge
//                are rejected as glitches.
//  Ports       : Clk          in   system clock
//                reset        in   synchronous, active-low reset
//                hall_clk     in   one-cycle edge strobe
//                hall_dir     in   direction sampled with hall_clk, 1 = up
//                pos_count    out  signed wrapping position
//                period       out  clocks between last two same-direction edges
//                period_valid out  one-cycle strobe, period updated
//                stalled      out  high while in the stall state
//                speed_count  out  signed edges in last complete window
//                window_valid out  one-cycle strobe at window close
//                reject       out  one-cycle strobe, edge discarded as glitch
//  Revision    : 1.0  initial release
// ============================================================================
module hall_speed_meter
  import hall_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int PERIOD_W      = 16,
  parameter int WINDOW_CYCLES = 50000,
  parameter int WIN_W         = 16,
  parameter int MIN_GAP       = 8,
  parameter int STALL_CYCLES  = 60000
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                hall_clk,
  input  logic                hall_dir,
  output logic [CNT_W-1:0]    pos_count,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stalled,
  output logic [WIN_W-1:0]    speed_count,
  output logic                window_valid,
  output logic                reject
);

  localparam logic [PERIOD_W-1:0] C_GAP_MAX = PERIOD_W'(gap_max(PERIOD_W));
  localparam logic [PERIOD_W-1:0] C_GAP_ONE = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] C_MIN_GAP = PERIOD_W'(MIN_GAP);
  localparam logic [PERIOD_W-1:0] C_STALL   = PERIOD_W'(STALL_CYCLES);
  localparam logic [CNT_W-1:0]    C_CNT_ONE = CNT_W'(1);

  hall_state_e         state_q, state_d;
  logic [PERIOD_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]    pos_count_q, pos_count_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                period_valid_q, period_valid_d;
  logic                stalled_q, stalled_d;
  logic                reject_q, reject_d;
  logic                last_dir_q, last_dir_d;
  logic                acc;
  logic                stall_hit;
  logic                same_dir;

  always_comb begin
    acc       = hall_clk && (gap_cnt_q >= C_MIN_GAP);
    // The threshold is hit exactly once while counting up; an edge in that
    // same cycle takes priority and restarts the gap.
    stall_hit = (gap_cnt_q == C_STALL) && !acc;
    same_dir  = (hall_dir == last_dir_q);

    if (acc)                         gap_cnt_d = C_GAP_ONE;
    else if (gap_cnt_q == C_GAP_MAX) gap_cnt_d = gap_cnt_q;
    else                             gap_cnt_d = gap_cnt_q + C_GAP_ONE;

    pos_count_d = pos_count_q;
    if (acc) pos_count_d = hall_dir ? pos_count_q + C_CNT_ONE : pos_count_q - C_CNT_ONE;

    last_dir_d = acc ? hall_dir : last_dir_q;
    reject_d   = hall_clk && !acc;
  end

  // Period/stall FSM. A reversal always drops back to FIRST because the gap
  // spanning a direction change is not a valid speed sample.
  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    period_valid_d = 1'b0;

    case (state_q)
      ST_STALL: begin
        if (acc) state_d = ST_FIRST;
      end
      ST_FIRST: begin
        if (acc) begin
          if (same_dir) begin
            state_d        = ST_RUN;
            period_d       = gap_cnt_q;
            period_valid_d = 1'b1;
          end
        end else if (stall_hit) begin
          state_d = ST_STALL;
        end
      end
      ST_RUN: begin
        if (acc) begin
          if (same_dir) begin
            period_d       = gap_cnt_q;
            period_valid_d = 1'b1;
          end else begin
            state_d = ST_FIRST;
          end
        end else if (stall_hit) begin
          state_d  = ST_STALL;
          period_d = C_GAP_MAX;
        end
      end
      default: state_d = ST_STALL;
    endcase

    stalled_d = (state_d == ST_STALL);
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q        <= ST_STALL;
      gap_cnt_q      <= C_GAP_MAX;
      pos_count_q    <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      stalled_q      <= 1'b1;
      reject_q       <= 1'b0;
      last_dir_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      gap_cnt_q      <= gap_cnt_d;
      pos_count_q    <= pos_count_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      stalled_q      <= stalled_d;
      reject_q       <= reject_d;
      last_dir_q     <= last_dir_d;
    end
  end

  hall_window_acc #(
    .WINDOW_CYCLES (WINDOW_CYCLES),
    .WIN_W         (WIN_W)
  ) u_window_acc (
    .Clk          (Clk),
    .reset        (reset),
    .acc          (acc),
    .dir          (hall_dir),
    .speed_count  (speed_count),
    .window_valid (window_valid)
  );

  assign pos_count    = pos_count_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign stalled      = stalled_q;
  assign reject       = reject_q;

endmodule
`default_nettype wire

// File: tb/tb_hall_speed_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_hall_speed_meter
//  Description : Scoreboard bench for hall_speed_meter. The driver pushes the
//                expected period, window and reject strobes (tagged with the
//                cycle they must appear in); a negedge monitor pops and checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hall_speed_meter;

  localparam int CNT_W         = 32;
  localparam int PERIOD_W      = 16;
  localparam int WINDOW_CYCLES = 100;
  localparam int WIN_W         = 16;
  localparam int MIN_GAP       = 4;
  localparam int STALL_CYCLES  = 1000;

  localparam int K_REJ = 0;  // edge expected to be rejected
  localparam int K_ACC = 1;  // accepted, no period strobe
  localparam int K_PER = 2;  // accepted with period strobe

  logic                Clk = 1'b0;
  logic                reset = 1'b0;
  logic                hall_clk = 1'b0;
  logic                hall_dir = 1'b0;
  logic [CNT_W-1:0]    pos_count;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                stalled;
  logic [WIN_W-1:0]    speed_count;
  logic                window_valid;
  logic                reject;

  hall_speed_meter #(
    .CNT_W         (CNT_W),
    .PERIOD_W      (PERIOD_W),
    .WINDOW_CYCLES (WINDOW_CYCLES),
    .WIN_W         (WIN_W),
    .MIN_GAP       (MIN_GAP),
    .STALL_CYCLES  (STALL_CYCLES)
  ) dut (
    .Clk          (Clk),
    .reset        (reset),
    .hall_clk     (hall_clk),
    .hall_dir     (hall_dir),
    .pos_count    (pos_count),
    .period       (period),
    .period_valid (period_valid),
    .stalled      (stalled),
    .speed_count  (speed_count),
    .window_valid (window_valid),
    .reject       (reject)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int stamp;
    int val;
  } ent_t;

  ent_t pq[$];
  ent_t wq[$];
  ent_t rq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;      // posedges completed since reset release
  int win_model = 0;  // signed edges in the currently open window
  int pos_model = 0;
  bit run = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string nm, input int at);
    total++;
    bad++;
    $display("FAIL %s: event for cycle %0d not matched (now %0d)", nm, at, cyc);
  endtask

  // One clock: inputs are set before the posedge that samples them.
  task automatic step(input logic h, input logic d, input int kind, input int per);
    hall_clk = h;
    hall_dir = d;
    @(posedge Clk);
    if (h) begin
      if (kind == K_REJ) begin
        rq.push_back('{cyc + 1, pos_model});
      end else begin
        win_model += d ? 1 : -1;
        pos_model += d ? 1 : -1;
      end
      if (kind == K_PER) pq.push_back('{cyc + 1, per});
    end
    if (cyc % WINDOW_CYCLES == WINDOW_CYCLES - 1) begin
      wq.push_back('{cyc + 1, win_model});
      win_model = 0;
    end
    cyc++;
    #1;
    hall_clk = 1'b0;
  endtask

  task automatic idle_until(input int p);
    if (p < cyc) fail_evt("schedule", p);
    while (cyc < p) step(1'b0, hall_dir, K_ACC, 0);
  endtask

  task automatic edge_at(input int p, input logic d, input int kind, input int per);
    idle_until(p);
    step(1'b1, d, kind, per);
  endtask

  // Monitor: a queued entry whose cycle has passed without its strobe is a
  // miss; a strobe with no entry for this cycle is unexpected.
  always @(negedge Clk) begin
    if (run) begin
      while (pq.size() > 0 && (pq[0].stamp < cyc || (!period_valid && pq[0].stamp == cyc))) begin
        fail_evt("period_valid_missing", pq[0].stamp);
        void'(pq.pop_front());
      end
      if (period_valid) begin
        if (pq.size() > 0 && pq[0].stamp == cyc) begin
          chk("period", longint'(period), longint'(pq[0].val));
          void'(pq.pop_front());
        end else begin
          fail_evt("period_valid_unexpected", cyc);
        end
      end

      while (wq.size() > 0 && (wq[0].stamp < cyc || (!window_valid && wq[0].stamp == cyc))) begin
        fail_evt("window_valid_missing", wq[0].stamp);
        void'(wq.pop_front());
      end
      if (window_valid) begin
        if (wq.size() > 0 && wq[0].stamp == cyc) begin
          chk("speed_count", longint'($signed(speed_count)), longint'(wq[0].val));
          void'(wq.pop_front());
        end else begin
          fail_evt("window_valid_unexpected", cyc);
        end
      end

      while (rq.size() > 0 && (rq[0].stamp < cyc || (!reject && rq[0].stamp == cyc))) begin
        fail_evt("reject_missing", rq[0].stamp);
        void'(rq.pop_front());
      end
      if (reject) begin
        if (rq.size() > 0 && rq[0].stamp == cyc) begin
          chk("reject_pos_hold", longint'($signed(pos_count)), longint'(rq[0].val));
          void'(rq.pop_front());
        end else begin
          fail_evt("reject_unexpected", cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    reset = 1'b1;
    cyc = 0;
    run = 1'b1;

    // Reset state
    chk("rst_stalled", longint'(stalled), 1);
    chk("rst_pos", longint'($signed(pos_count)), 0);
    chk("rst_period", longint'(period), 0);
    chk("rst_speed", longint'($signed(speed_count)), 0);
    chk("rst_strobes", longint'({period_valid, window_valid, reject}), 0);

    // Forward run: 10 edges, 20 cycles apart, windows 100..199 and 200..299
    edge_at(100, 1'b1, K_ACC, 0);
    chk("first_edge_unstall", longint'(stalled), 0);
    for (int i = 1; i < 10; i++) edge_at(100 + 20 * i, 1'b1, K_PER, 20);
    chk("fwd_pos", longint'($signed(pos_count)), 10);

    // Glitch: edge 2 cycles after an accepted edge is rejected; gap keeps
    // counting from the accepted edge
    edge_at(300, 1'b1, K_PER, 20);
    edge_at(302, 1'b1, K_REJ, 0);
    chk("glitch_pos", longint'($signed(pos_count)), 11);
    edge_at(320, 1'b1, K_PER, 20);

    // Reversal
    edge_at(340, 1'b1, K_PER, 20);
    edge_at(360, 1'b1, K_PER, 20);
    edge_at(380, 1'b1, K_PER, 20);
    chk("pre_rev_pos", longint'($signed(pos_count)), 15);
    edge_at(400, 1'b0, K_ACC, 0);
    chk("rev_pos", longint'($signed(pos_count)), 14);
    edge_at(420, 1'b0, K_PER, 20);
    edge_at(440, 1'b0, K_PER, 20);
    chk("rev_run_pos", longint'($signed(pos_count)), 12);

    // Stall: gap reaches 1000 at posedge 1440
    idle_until(1440);
    chk("pre_stall_flag", longint'(stalled), 0);
    chk("pre_stall_period", longint'(period), 20);
    idle_until(1441);
    chk("stall_flag", longint'(stalled), 1);
    chk("stall_period", longint'(period), 65535);
    edge_at(1460, 1'b1, K_ACC, 0);
    chk("unstall_flag", longint'(stalled), 0);

    // Window boundaries: edge on last window cycle, edge on first cycle,
    // reject on first cycle, negative window total
    edge_at(1499, 1'b1, K_PER, 39);
    edge_at(1600, 1'b0, K_ACC, 0);
    edge_at(1620, 1'b0, K_PER, 20);
    edge_at(1640, 1'b0, K_PER, 20);
    edge_at(1699, 1'b0, K_PER, 59);
    edge_at(1700, 1'b0, K_REJ, 0);
    edge_at(1710, 1'b0, K_PER, 11);
    idle_until(1803);
    chk("final_pos", longint'($signed(pos_count)), 9);

    chk("period_queue_drained", longint'(pq.size()), 0);
    chk("window_queue_drained", longint'(wq.size()), 0);
    chk("reject_queue_drained", longint'(rq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
